// File: rtl/fifo_wr_arbiter.sv
// Write-side burst arbiter for the pixel FIFO: round-robins the camera stream (port 0)
// and header/status words (port 1) onto one registered FIFO write port in bursts.
module fifo_wr_arbiter #(
  parameter int DATA_SIZE = 16,
  parameter int BURST_LEN = 4
) (
  input  logic                 w_clk,
  input  logic                 w_rst,
  input  logic                 req0_valid,
  input  logic [DATA_SIZE-1:0] req0_data,
  input  logic                 req0_last,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DATA_SIZE-1:0] req1_data,
  input  logic                 req1_last,
  output logic                 req1_ready,
  input  logic                 fifo_almost_full,
  input  logic                 fifo_full,
  output logic                 fifo_w_en,
  output logic [DATA_SIZE-1:0] fifo_w_data,
  output logic [1:0]           grant,
  output logic                 ovf_err
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

  state_t               state, state_nxt;
  logic [1:0]           grant_nxt;
  logic                 last_owner, last_owner_nxt;
  logic [CNT_W-1:0]     beat_cnt, beat_cnt_nxt;
  logic                 hs;
  logic                 hs_last;
  logic [DATA_SIZE-1:0] hs_data;

  // Ready depends only on who owns the burst and the hard full stop.
  assign req0_ready = (state == BURST) & grant[0] & ~fifo_full;
  assign req1_ready = (state == BURST) & grant[1] & ~fifo_full;

  assign hs      = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign hs_data = grant[1] ? req1_data : req0_data;
  assign hs_last = grant[1] ? req1_last : req0_last;

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_owner_nxt = last_owner;
    beat_cnt_nxt   = beat_cnt;
    case (state)
      IDLE: begin
        if (!fifo_almost_full && (req0_valid || req1_valid)) begin
          // last_owner holds the index of the previous winner; the other port wins a tie.
          if (req1_valid && (!req0_valid || !last_owner)) begin
            grant_nxt      = 2'b10;
            last_owner_nxt = 1'b1;
          end else begin
            grant_nxt      = 2'b01;
            last_owner_nxt = 1'b0;
          end
          beat_cnt_nxt = '0;
          state_nxt    = BURST;
        end
      end
      BURST: begin
        if (hs) begin
          beat_cnt_nxt = beat_cnt + CNT_W'(1);
          if (hs_last || (beat_cnt == LAST_BEAT)) begin
            grant_nxt = 2'b00;
            state_nxt = GAP;
          end
        end
      end
      GAP: begin
        // One idle cycle lets the final write update almost-full before IDLE samples it.
        state_nxt = IDLE;
      end
      default: begin
        grant_nxt = 2'b00;
        state_nxt = IDLE;
      end
    endcase
  end

  // Stage boundary: handshake -> registered FIFO write, plus control state.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state       <= IDLE;
      grant       <= 2'b00;
      last_owner  <= 1'b1;
      beat_cnt    <= '0;
      fifo_w_en   <= 1'b0;
      fifo_w_data <= '0;
      ovf_err     <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_owner <= last_owner_nxt;
      beat_cnt   <= beat_cnt_nxt;
      fifo_w_en  <= hs;
      if (hs) begin
        fifo_w_data <= hs_data;
      end
      if (fifo_w_en && fifo_full) begin
        ovf_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a cycle table for bursts and round-robin,
// followed by hand-written almost-full, stall, reset and overflow sequences.
module tb_fifo_wr_arbiter;

  logic        w_clk;
  logic        w_rst;
  logic        req0_valid, req0_last, req0_ready;
  logic [15:0] req0_data;
  logic        req1_valid, req1_last, req1_ready;
  logic [15:0] req1_data;
  logic        fifo_almost_full, fifo_full;
  logic        fifo_w_en;
  logic [15:0] fifo_w_data;
  logic [1:0]  grant;
  logic        ovf_err;

  int n_pass  = 0;
  int n_total = 0;
  int wr_cnt  = 0;
  int w0;

  typedef struct packed {
    logic        v0;
    logic [15:0] d0;
    logic        l0;
    logic        v1;
    logic [15:0] d1;
    logic        l1;
    logic [1:0]  g;
    logic        r0;
    logic        r1;
    logic        wen;
    logic [15:0] wd;
  } vec_t;

  vec_t tbl[$];

  fifo_wr_arbiter #(.DATA_SIZE(16), .BURST_LEN(4)) dut (
    .w_clk            (w_clk),
    .w_rst            (w_rst),
    .req0_valid       (req0_valid),
    .req0_data        (req0_data),
    .req0_last        (req0_last),
    .req0_ready       (req0_ready),
    .req1_valid       (req1_valid),
    .req1_data        (req1_data),
    .req1_last        (req1_last),
    .req1_ready       (req1_ready),
    .fifo_almost_full (fifo_almost_full),
    .fifo_full        (fifo_full),
    .fifo_w_en        (fifo_w_en),
    .fifo_w_data      (fifo_w_data),
    .grant            (grant),
    .ovf_err          (ovf_err)
  );

  initial begin
    w_clk = 1'b0;
    forever #5 w_clk = ~w_clk;
  end

  always @(negedge w_clk) begin
    if (fifo_w_en) wr_cnt <= wr_cnt + 1;
  end

  function automatic vec_t mk(logic v0, logic [15:0] d0, logic l0, logic v1, logic [15:0] d1,
                              logic l1, logic [1:0] g, logic r0, logic r1, logic wen,
                              logic [15:0] wd);
    vec_t t;
    t.v0 = v0; t.d0 = d0; t.l0 = l0;
    t.v1 = v1; t.d1 = d1; t.l1 = l1;
    t.g = g; t.r0 = r0; t.r1 = r1; t.wen = wen; t.wd = wd;
    return t;
  endfunction

  function automatic logic [21:0] obs();
    return {grant, req0_ready, req1_ready, fifo_w_en, ovf_err, fifo_w_data};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic cyc(input logic v0, input logic [15:0] d0, input logic l0,
                     input logic v1, input logic [15:0] d1, input logic l1);
    @(negedge w_clk);
    req0_valid = v0; req0_data = d0; req0_last = l0;
    req1_valid = v1; req1_data = d1; req1_last = l1;
    #1;
  endtask

  initial begin
    w_rst = 1'b1;
    req0_valid = 0; req0_data = 0; req0_last = 0;
    req1_valid = 0; req1_data = 0; req1_last = 0;
    fifo_almost_full = 0; fifo_full = 0;

    //          v0 d0       l0 v1 d1       l1  grant  r0 r1 wen wdata
    tbl.push_back(mk(1, 16'h0001, 0, 0, 16'h0000, 0, 2'b00, 0, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 16'h0001, 0, 0, 16'h0000, 0, 2'b01, 1, 0, 0, 16'h0000));
    tbl.push_back(mk(1, 16'h0002, 0, 0, 16'h0000, 0, 2'b01, 1, 0, 1, 16'h0001));
    tbl.push_back(mk(1, 16'h0003, 0, 0, 16'h0000, 0, 2'b01, 1, 0, 1, 16'h0002));
    tbl.push_back(mk(1, 16'h0004, 0, 0, 16'h0000, 0, 2'b01, 1, 0, 1, 16'h0003));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 2'b00, 0, 0, 1, 16'h0004));
    tbl.push_back(mk(1, 16'h0010, 0, 1, 16'h0020, 0, 2'b00, 0, 0, 0, 16'h0004));
    tbl.push_back(mk(1, 16'h0010, 0, 1, 16'h0020, 0, 2'b10, 0, 1, 0, 16'h0004));
    tbl.push_back(mk(1, 16'h0010, 0, 1, 16'h0021, 0, 2'b10, 0, 1, 1, 16'h0020));
    tbl.push_back(mk(1, 16'h0010, 0, 1, 16'h0022, 0, 2'b10, 0, 1, 1, 16'h0021));
    tbl.push_back(mk(1, 16'h0010, 0, 1, 16'h0023, 0, 2'b10, 0, 1, 1, 16'h0022));
    tbl.push_back(mk(1, 16'h0010, 0, 1, 16'h0030, 0, 2'b00, 0, 0, 1, 16'h0023));
    tbl.push_back(mk(1, 16'h0010, 0, 1, 16'h0030, 0, 2'b00, 0, 0, 0, 16'h0023));
    tbl.push_back(mk(1, 16'h0010, 0, 1, 16'h0030, 0, 2'b01, 1, 0, 0, 16'h0023));
    tbl.push_back(mk(1, 16'h0011, 0, 1, 16'h0030, 0, 2'b01, 1, 0, 1, 16'h0010));
    tbl.push_back(mk(1, 16'h0012, 0, 1, 16'h0030, 0, 2'b01, 1, 0, 1, 16'h0011));
    tbl.push_back(mk(1, 16'h0013, 0, 1, 16'h0030, 0, 2'b01, 1, 0, 1, 16'h0012));
    tbl.push_back(mk(1, 16'h0014, 0, 1, 16'h0030, 0, 2'b00, 0, 0, 1, 16'h0013));
    tbl.push_back(mk(1, 16'h0014, 0, 1, 16'h0030, 1, 2'b00, 0, 0, 0, 16'h0013));
    tbl.push_back(mk(1, 16'h0014, 0, 1, 16'h0030, 1, 2'b10, 0, 1, 0, 16'h0013));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 2'b00, 0, 0, 1, 16'h0030));
    tbl.push_back(mk(0, 16'h0000, 0, 0, 16'h0000, 0, 2'b00, 0, 0, 0, 16'h0030));

    #2;
    chk("reset_state", 32'(obs()), 32'(0));
    @(negedge w_clk);
    w_rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].v0, tbl[i].d0, tbl[i].l0, tbl[i].v1, tbl[i].d1, tbl[i].l1);
      chk($sformatf("vec%0d", i), 32'(obs()),
          32'({tbl[i].g, tbl[i].r0, tbl[i].r1, tbl[i].wen, 1'b0, tbl[i].wd}));
    end

    // Almost-full holds off a new grant.
    fifo_almost_full = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc(0, 16'h0, 0, 1, 16'h0040, 1);
      chk($sformatf("af_hold%0d", i), 32'({grant, req1_ready}), 32'(0));
    end
    cyc(0, 16'h0, 0, 1, 16'h0040, 1);
    fifo_almost_full = 1'b0;
    chk("af_fall_cycle", 32'(grant), 32'(0));
    cyc(0, 16'h0, 0, 1, 16'h0040, 1);
    chk("af_grant", 32'({grant, req1_ready}), 32'({2'b10, 1'b1}));
    cyc(0, 16'h0, 0, 0, 16'h0, 0);
    chk("af_write", 32'({grant, fifo_w_en, fifo_w_data}), 32'({2'b00, 1'b1, 16'h0040}));
    cyc(0, 16'h0, 0, 0, 16'h0, 0);

    // Early last after two words.
    cyc(1, 16'h0051, 0, 0, 16'h0, 0);
    w0 = wr_cnt;
    cyc(1, 16'h0051, 0, 0, 16'h0, 0);
    chk("early_grant", 32'(grant), 32'(2'b01));
    cyc(1, 16'h0052, 1, 0, 16'h0, 0);
    cyc(0, 16'h0, 0, 0, 16'h0, 0);
    chk("early_gap", 32'({grant, fifo_w_en, fifo_w_data}), 32'({2'b00, 1'b1, 16'h0052}));
    cyc(0, 16'h0, 0, 0, 16'h0, 0);
    chk("early_writes", 32'(wr_cnt - w0), 32'(2));

    // Stall mid-burst: grant held, four words total.
    cyc(1, 16'h0061, 0, 0, 16'h0, 0);
    w0 = wr_cnt;
    cyc(1, 16'h0061, 0, 0, 16'h0, 0);
    cyc(1, 16'h0062, 0, 0, 16'h0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 16'h0, 0, 0, 16'h0, 0);
      chk($sformatf("stall_hold%0d", i), 32'({grant, req0_ready}), 32'({2'b01, 1'b1}));
    end
    cyc(1, 16'h0063, 0, 0, 16'h0, 0);
    cyc(1, 16'h0064, 0, 0, 16'h0, 0);
    cyc(0, 16'h0, 0, 0, 16'h0, 0);
    chk("stall_gap", 32'({grant, fifo_w_en, fifo_w_data}), 32'({2'b00, 1'b1, 16'h0064}));
    cyc(0, 16'h0, 0, 0, 16'h0, 0);
    chk("stall_writes", 32'(wr_cnt - w0), 32'(4));

    // Asynchronous reset after the second handshake.
    cyc(1, 16'h0071, 0, 0, 16'h0, 0);
    cyc(1, 16'h0071, 0, 0, 16'h0, 0);
    cyc(1, 16'h0072, 0, 0, 16'h0, 0);
    cyc(1, 16'h0073, 0, 1, 16'h0081, 0);
    chk("rst_pending", 32'({fifo_w_en, fifo_w_data}), 32'({1'b1, 16'h0072}));
    w_rst = 1'b1;
    #1;
    chk("rst_async", 32'(obs()), 32'(0));
    w_rst = 1'b0;
    cyc(1, 16'h0073, 1, 1, 16'h0081, 0);
    chk("rst_tie", 32'({grant, fifo_w_en}), 32'({2'b01, 1'b0}));
    cyc(0, 16'h0, 0, 0, 16'h0, 0);
    chk("rst_after", 32'({grant, fifo_w_en, fifo_w_data}), 32'({2'b00, 1'b1, 16'h0073}));
    cyc(0, 16'h0, 0, 0, 16'h0, 0);

    // Overflow guard.
    cyc(1, 16'h0091, 0, 0, 16'h0, 0);
    cyc(1, 16'h0091, 0, 0, 16'h0, 0);
    fifo_full = 1'b1;
    #1;
    chk("full_ready", 32'({grant, req0_ready}), 32'({2'b01, 1'b0}));
    cyc(1, 16'h0091, 0, 0, 16'h0, 0);
    fifo_full = 1'b0;
    cyc(1, 16'h0092, 0, 0, 16'h0, 0);
    fifo_full = 1'b1;
    #1;
    chk("ovf_case", 32'({req0_ready, fifo_w_en, ovf_err}), 32'({1'b0, 1'b1, 1'b0}));
    cyc(1, 16'h0092, 1, 0, 16'h0, 0);
    fifo_full = 1'b0;
    #1;
    chk("ovf_set", 32'({ovf_err, req0_ready, fifo_w_en}), 32'({1'b1, 1'b1, 1'b0}));
    for (int i = 0; i < 3; i++) begin
      cyc(0, 16'h0, 0, 0, 16'h0, 0);
      chk($sformatf("ovf_sticky%0d", i), 32'(ovf_err), 32'(1));
    end
    w_rst = 1'b1;
    #1;
    chk("ovf_reset", 32'(ovf_err), 32'(0));
    w_rst = 1'b0;
    cyc(0, 16'h0, 0, 0, 16'h0, 0);
    chk("final_idle", 32'(obs()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side burst arbiter for the asynchronous pixel FIFO, in the `w_clk` domain. It shares the FIFO write port between two requesters: port 0 carries the camera pixel stream and port 1 carries frame header/status words. Each grant is a burst of up to `BURST_LEN` words. The block starts a burst only while the FIFO's `w_almost_full` indicator is low, so no word is lost and the hard `w_full` stop is never reached in normal operation.

## Interface
- `DATA_SIZE`, 16, width of each data word.
- `BURST_LEN`, 4, maximum number of words per grant; legal range 1..64. The FIFO must be built with almost-full position ≥ `BURST_LEN`+2.
- `w_clk`  in  1  write-domain clock.
- `w_rst`  in  1  reset; asynchronous, active-high.
- `req0_valid` / `req1_valid`  in  1  requester holds a valid word.
- `req0_data` / `req1_data`  in  `DATA_SIZE`  requester word.
- `req0_last` / `req1_last`  in  1  qualifies the current word as the final word of the burst.
- `req0_ready` / `req1_ready`  out  1  the word is accepted on any cycle where valid and ready are both high.
- `fifo_almost_full`  in  1  FIFO almost-full flag, same domain.
- `fifo_full`  in  1  FIFO full flag, same domain.
- `fifo_w_en`  out  1  FIFO write enable, registered.
- `fifo_w_data`  out  `DATA_SIZE`  FIFO write data, registered.
- `grant`  out  2  one-hot owner of the current burst; 00 when no burst is active.
- `ovf_err`  out  1  sticky error: set if `fifo_w_en` is ever high while `fifo_full` is high.

## Operation
- The state machine has three states: IDLE, BURST and GAP. Reset enters IDLE.
- **IDLE:**
  - If `fifo_almost_full` is 0 and any `reqN_valid` is 1, the block picks an owner, sets `grant`, clears the beat counter and moves to BURST.
  - Otherwise it stays in IDLE.
- **Arbitration** is round-robin with a `last_owner` register that resets so that port 0 wins the first tie.
  - If only one port requests, that port wins.
  - If both request, the port that is not `last_owner` wins.
  - `last_owner` updates when a grant is issued.
- **BURST:**
  - `reqN_ready` = (`grant[N]` & !`fifo_full`). The ready of the non-owner is always 0.
  - On each handshake the word is registered onto `fifo_w_data`, `fifo_w_en` is 1 on the next cycle, and the beat counter increments.
  - Counter width is $clog2(`BURST_LEN`+1); the counter never wraps.
  - The burst ends on the handshake that carries `last` or that brings the counter to `BURST_LEN`, whichever comes first. The block then moves to GAP and `grant` returns to 00.
  - If the owner drops valid, the burst stalls: grant is held, there is no timeout and the counter is unchanged.
- **GAP** lasts exactly one cycle, then the block returns to IDLE. It lets the final write land so that `fifo_almost_full` is current when IDLE samples it.
- `fifo_almost_full` rising during BURST does not cut the burst short; the margin required on the FIFO's almost-full position covers the remaining words.
- `fifo_w_en` is 0 on every cycle without a preceding handshake.
- `ovf_err` is cleared only by `w_rst`.
- **Reset mid-burst:**
  - All state returns to IDLE immediately and `last_owner` is restored to its reset value.
  - Any pending registered write is discarded: `fifo_w_en` goes to 0 asynchronously.

## Timing
- Reset values:
  - `fifo_w_en`=0, `fifo_w_data`=0, `grant`=00, `req0_ready`=0, `req1_ready`=0, `ovf_err`=0.
  - Internal: state=IDLE, beat counter=0.
- Cycle T (IDLE): the request is seen. T+1: BURST, `grant` and ready are high. The first handshake can occur at T+1.
- Latency from handshake to FIFO write is 1 cycle. Throughput is 1 word per cycle during a burst.
- **Burst sequence:**
  - The last handshake is at cycle L.
  - L+1: GAP, with `fifo_w_en` high for the final word.
  - L+2: IDLE.
  - The earliest next handshake is at L+3.
- `reqN_ready` is combinational from state and `fifo_full` only. It never depends on `reqN_valid`.

## Test plan
- **Single burst:**
  - Stimulus: `BURST_LEN`=4; `req0_valid` steady with data 0x0001..0x0004; FIFO not almost-full.
  - Required: `grant`=01; four handshakes on consecutive cycles; `fifo_w_en` high for 4 cycles, delayed one cycle, with data 0x0001..0x0004; GAP; `grant`=00.
- **Round-robin:**
  - Stimulus: both ports valid continuously.
  - Required: grants alternate 01, 10, 01, 10; bursts are separated by exactly 2 non-ready cycles.
- **Almost-full hold:**
  - Stimulus: `fifo_almost_full`=1 with `req1_valid`=1 for 10 cycles, then 0.
  - Required: `grant` stays 00 throughout; `grant`=10 one cycle after the flag falls.
- **Early last and stall:**
  - Stimulus: port 0 sends 2 words with `last` on the second word. A second burst then drops valid for 3 cycles mid-burst.
  - Required: the first burst ends after 2 writes. The second burst holds `grant` through the stall and writes exactly 4 words in total.
- **Reset mid-burst:**
  - Stimulus: `w_rst` pulses asynchronously after the 2nd handshake.
  - Required: all outputs go to their reset values immediately with no further `fifo_w_en`. After reset, a tie between the ports grants port 0 first.
- **Overflow guard:**
  - Stimulus: force `fifo_full`=1 on the cycle that carries a registered write.
  - Required: `ovf_err` rises and stays at 1 until reset, and `reqN_ready` is 0 while `fifo_full` is high.
